// File: rtl/easter_egg_pkg.sv
// Shared types and PIO byte field positions for the easter-egg effect controller.
package easter_egg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int TRIG_BIT = 7;
  localparam int MODE_HI  = 6;
  localparam int MODE_LO  = 4;
  localparam int DUR_HI   = 3;
  localparam int DUR_LO   = 0;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick: one-cycle pulse on the falling edge of the active-low VGA vsync.
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vs,
  output logic o_tick
);

  logic r_vs_q;

  // vs idles high, so the history resets high to avoid a false tick after reset
  always_ff @(posedge i_clk) begin
    if (i_reset) r_vs_q <= 1'b1;
    else         r_vs_q <= i_vs;
  end

  assign o_tick = r_vs_q & ~i_vs;

endmodule

// File: rtl/easter_egg_ctrl.sv
// Turns each new easter-egg PIO byte into a timed effect (mode + frame count),
// followed by a fixed cooldown during which further commands are dropped.
module easter_egg_ctrl
  import easter_egg_pkg::*;
#(
  parameter int UNIT_FRAMES     = 16,
  parameter int CNT_W           = 8,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       egg_code,
  input  logic             vs,
  output logic             egg_active,
  output logic [2:0]       egg_mode,
  output logic [CNT_W-1:0] frames_left,
  output logic             egg_start,
  output logic             egg_done
);

  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] UNIT_LD = CNT_W'(UNIT_FRAMES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           r_state, w_state_n;
  logic [7:0]       r_prev_code;
  logic [2:0]       r_mode, w_mode_n;
  logic [CNT_W-1:0] r_frames, w_frames_n;
  logic             r_start, w_start_n;
  logic             r_done, w_done_n;

  logic             w_tick;
  logic             w_new_cmd, w_trig, w_cancel;
  logic [3:0]       w_dur;
  logic [CNT_W-1:0] w_load;

  frame_tick_gen u_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .i_vs    (vs),
    .o_tick  (w_tick)
  );

  // A command is a change of the byte; zero duration or a clear trigger bit means cancel
  assign w_dur     = egg_code[DUR_HI:DUR_LO];
  assign w_new_cmd = (egg_code != r_prev_code);
  assign w_trig    = w_new_cmd & egg_code[TRIG_BIT] & (w_dur != 4'd0);
  assign w_cancel  = w_new_cmd & (~egg_code[TRIG_BIT] | (w_dur == 4'd0));
  assign w_load    = CNT_W'(w_dur) * UNIT_LD;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_prev_code <= 8'd0;
      r_mode      <= 3'd0;
      r_frames    <= '0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_prev_code <= egg_code;
      r_mode      <= w_mode_n;
      r_frames    <= w_frames_n;
      r_start     <= w_start_n;
      r_done      <= w_done_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_mode_n   = r_mode;
    w_frames_n = r_frames;
    w_start_n  = 1'b0;
    w_done_n   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_n  = ACTIVE;
          w_mode_n   = egg_code[MODE_HI:MODE_LO];
          w_frames_n = w_load;
          w_start_n  = 1'b1;
        end
      end
      ACTIVE: begin
        // Retrigger wins over cancel and expiry, so it never emits egg_done
        if (w_trig) begin
          w_mode_n   = egg_code[MODE_HI:MODE_LO];
          w_frames_n = w_load;
          w_start_n  = 1'b1;
        end else if (w_cancel || (w_tick && r_frames == ONE)) begin
          w_state_n  = COOLDOWN;
          w_frames_n = COOL_LD;
          w_done_n   = 1'b1;
        end else if (w_tick && r_frames != '0) begin
          w_frames_n = r_frames - ONE;
        end
      end
      COOLDOWN: begin
        if (w_tick && r_frames == ONE) begin
          w_state_n  = IDLE;
          w_frames_n = '0;
        end else if (w_tick && r_frames != '0) begin
          w_frames_n = r_frames - ONE;
        end
      end
      default: begin
        w_state_n  = IDLE;
        w_frames_n = '0;
      end
    endcase
  end

  assign egg_active  = (r_state == ACTIVE);
  assign egg_mode    = r_mode;
  assign frames_left = r_frames;
  assign egg_start   = r_start;
  assign egg_done    = r_done;

endmodule

// File: tb/tb_easter_egg_ctrl.sv
// Directed bench for easter_egg_ctrl: a behavioural model fills a scoreboard per cycle.
module tb_easter_egg_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] egg_code;
  logic       vs;
  logic       egg_active;
  logic [2:0] egg_mode;
  logic [7:0] frames_left;
  logic       egg_start;
  logic       egg_done;

  easter_egg_ctrl #(
    .UNIT_FRAMES     (16),
    .CNT_W           (8),
    .COOLDOWN_FRAMES (60)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .egg_code    (egg_code),
    .vs          (vs),
    .egg_active  (egg_active),
    .egg_mode    (egg_mode),
    .frames_left (frames_left),
    .egg_start   (egg_start),
    .egg_done    (egg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       act;
    logic [2:0] mode;
    logic [7:0] fl;
    logic       st;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fails   = 0;

  // model state: 0 idle, 1 active, 2 cooldown
  int         m_state;
  logic [7:0] m_prev;
  logic       m_vsq;
  logic [2:0] m_mode;
  int         m_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model(input logic [7:0] c, input logic v, input logic r, output exp_t e);
    bit nc, tr, cn, tk;
    bit st, dn;
    st = 0;
    dn = 0;
    if (r) begin
      m_state = 0; m_prev = 8'h00; m_vsq = 1'b1; m_mode = 3'd0; m_fl = 0;
    end else begin
      nc = (c != m_prev);
      tr = nc && c[7] && (c[3:0] != 4'd0);
      cn = nc && !tr;
      tk = m_vsq && !v;
      if (m_state == 0) begin
        if (tr) begin m_state = 1; m_mode = c[6:4]; m_fl = int'(c[3:0]) * 16; st = 1; end
      end else if (m_state == 1) begin
        if (tr) begin m_mode = c[6:4]; m_fl = int'(c[3:0]) * 16; st = 1; end
        else if (cn || (tk && m_fl == 1)) begin m_state = 2; m_fl = 60; dn = 1; end
        else if (tk && m_fl > 0) m_fl = m_fl - 1;
      end else begin
        if (tk) begin
          if (m_fl == 1) begin m_state = 0; m_fl = 0; end
          else if (m_fl > 0) m_fl = m_fl - 1;
        end
      end
      m_prev = c;
      m_vsq  = v;
    end
    e.act  = (m_state == 1);
    e.mode = m_mode;
    e.fl   = m_fl[7:0];
    e.st   = st;
    e.dn   = dn;
  endtask

  task automatic step(input logic [7:0] c, input logic v, input logic r);
    exp_t e;
    egg_code = c;
    vs       = v;
    reset    = r;
    model(c, v, r, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("active", 32'(egg_active), 32'(e.act));
    chk("mode", 32'(egg_mode), 32'(e.mode));
    chk("frames_left", 32'(frames_left), 32'(e.fl));
    chk("start", 32'(egg_start), 32'(e.st));
    chk("done", 32'(egg_done), 32'(e.dn));
    chk("start_done_excl", 32'(egg_start & egg_done), 32'd0);
  endtask

  task automatic frames(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      step(c, 1'b0, 1'b0);
      step(c, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    egg_code = 8'h00;
    vs       = 1'b1;

    // reset and idle frames
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    chk("rst_frames", 32'(frames_left), 32'd0);
    chk("rst_active", 32'(egg_active), 32'd0);
    frames(8'h00, 5);
    chk("idle_active", 32'(egg_active), 32'd0);

    // full effect: 2 units, then cooldown
    step(8'h92, 1'b1, 1'b0);
    chk("x92_start", 32'(egg_start), 32'd1);
    chk("x92_mode", 32'(egg_mode), 32'd1);
    chk("x92_frames", 32'(frames_left), 32'd32);
    frames(8'h92, 31);
    chk("x92_last", 32'(frames_left), 32'd1);
    step(8'h92, 1'b0, 1'b0);
    chk("expire_done", 32'(egg_done), 32'd1);
    chk("expire_cool", 32'(frames_left), 32'd60);
    step(8'h92, 1'b1, 1'b0);
    frames(8'h92, 59);
    step(8'h92, 1'b0, 1'b0);
    chk("cool_end", 32'(frames_left), 32'd0);
    step(8'h92, 1'b1, 1'b0);

    // retrigger, plain and coincident with a tick
    step(8'h00, 1'b1, 1'b0);
    step(8'h92, 1'b1, 1'b0);
    frames(8'h92, 12);
    chk("pre_retrig", 32'(frames_left), 32'd20);
    step(8'hB5, 1'b1, 1'b0);
    chk("retrig_frames", 32'(frames_left), 32'd80);
    step(8'hA5, 1'b0, 1'b0);
    chk("retrig_tick_start", 32'(egg_start), 32'd1);
    chk("retrig_tick_mode", 32'(egg_mode), 32'd2);
    chk("retrig_tick_frames", 32'(frames_left), 32'd80);
    chk("retrig_tick_done", 32'(egg_done), 32'd0);
    step(8'hA5, 1'b1, 1'b0);

    // cancel, then commands dropped during cooldown
    step(8'h12, 1'b1, 1'b0);
    chk("cancel_done", 32'(egg_done), 32'd1);
    chk("cancel_frames", 32'(frames_left), 32'd60);
    step(8'h93, 1'b1, 1'b0);
    chk("cool_drop_start", 32'(egg_start), 32'd0);
    frames(8'h93, 59);
    step(8'h94, 1'b0, 1'b0);
    chk("final_tick_trig_drop", 32'(egg_start), 32'd0);
    chk("final_tick_idle", 32'(frames_left), 32'd0);
    step(8'h94, 1'b1, 1'b0);

    // zero duration is a no-op, repeated write invisible
    step(8'h90, 1'b1, 1'b0);
    step(8'h90, 1'b1, 1'b0);
    chk("dur0_active", 32'(egg_active), 32'd0);
    step(8'h90, 1'b0, 1'b0);
    step(8'h90, 1'b1, 1'b0);

    // reset mid-effect
    step(8'h81, 1'b1, 1'b0);
    chk("x81_frames", 32'(frames_left), 32'd16);
    frames(8'h81, 6);
    chk("pre_reset", 32'(frames_left), 32'd10);
    step(8'h00, 1'b1, 1'b1);
    chk("midrst_done", 32'(egg_done), 32'd0);
    chk("midrst_frames", 32'(frames_left), 32'd0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h81, 1'b1, 1'b0);
    chk("post_rst_start", 32'(egg_start), 32'd1);
    chk("post_rst_frames", 32'(frames_left), 32'd16);
    step(8'h81, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
